// File: rtl/iic_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module   : iic_cfg_seq
// Purpose  : Table-driven I2C configuration sequencer for MS7200/MS7210 HDMI
//            chips. Walks an external register table (1-cycle read latency)
//            and issues one single-byte write or read per entry to iic_dri.
//            Entry ops: WRITE, POLL (read until masked match), DELAY, END.
// Ports    : clk, rstn (sync active-low), cfg_start (restart pulse)
//            tbl_addr / tbl_data  : table ROM interface
//            device_id, iic_trig, w_r, addr, data_in : request to iic_dri
//            busy, data_out, byte_over              : status from iic_dri
//            init_over, cfg_err, err_idx            : completion / error
// Revision : 1.0 - initial release
// ============================================================================
module iic_cfg_seq #(
    parameter int TBL_AW   = 8,
    parameter int DLY_DIV  = 10_000,
    parameter int POLL_MAX = 16,
    parameter int POLL_GAP = 1,
    parameter int BUSY_TO  = 100_000
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cfg_start,
    output logic [TBL_AW-1:0] tbl_addr,
    input  logic [41:0]       tbl_data,
    output logic [7:0]        device_id,
    output logic              iic_trig,
    output logic              w_r,
    output logic [15:0]       addr,
    output logic [7:0]        data_in,
    input  logic              busy,
    input  logic [7:0]        data_out,
    input  logic              byte_over,
    output logic              init_over,
    output logic              cfg_err,
    output logic [TBL_AW-1:0] err_idx
);

    localparam int c_PRE_W = $clog2(DLY_DIV + 1);
    localparam int c_TMO_W = $clog2(BUSY_TO + 1);
    localparam logic [TBL_AW-1:0] c_IDX_MAX = '1;

    localparam logic [1:0] c_OP_WRITE = 2'b00;
    localparam logic [1:0] c_OP_POLL  = 2'b01;
    localparam logic [1:0] c_OP_DELAY = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_TRIG   = 4'd3,
        S_WAIT_H = 4'd4,
        S_WAIT_L = 4'd5,
        S_CHECK  = 4'd6,
        S_GAP    = 4'd7,
        S_DELAY  = 4'd8,
        S_NEXT   = 4'd9,
        S_DONE   = 4'd10,
        S_ERR    = 4'd11
    } state_t;

    state_t              r_state;
    logic                r_auto;      // one automatic run after reset
    logic [TBL_AW-1:0]   r_idx;
    logic [7:0]          r_dev;
    logic                r_wr;
    logic [15:0]         r_addr;
    logic [7:0]          r_data;
    logic [7:0]          r_mask;
    logic [7:0]          r_rdata;
    logic [7:0]          r_tries;
    logic [c_PRE_W-1:0]  r_pre;
    logic [23:0]         r_units;
    logic [c_TMO_W-1:0]  r_tmo;
    logic                r_trig;
    logic                r_init_over;
    logic                r_cfg_err;
    logic [TBL_AW-1:0]   r_err_idx;

    // byte_over is informational only; it does not steer the sequencer.
    logic w_unused_byte_over;
    assign w_unused_byte_over = byte_over;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_auto      <= 1'b1;
            r_idx       <= '0;
            r_dev       <= '0;
            r_wr        <= 1'b0;
            r_addr      <= '0;
            r_data      <= '0;
            r_mask      <= '0;
            r_rdata     <= '0;
            r_tries     <= '0;
            r_pre       <= '0;
            r_units     <= '0;
            r_tmo       <= '0;
            r_trig      <= 1'b0;
            r_init_over <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_err_idx   <= '0;
        end else begin
            r_trig <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (r_state == S_DONE) begin
                        r_init_over <= 1'b1;
                    end
                    if (r_state == S_ERR) begin
                        r_cfg_err <= 1'b1;
                        r_err_idx <= r_idx;
                    end
                    // r_auto is only ever set while sitting in IDLE after reset
                    if (cfg_start || r_auto) begin
                        r_auto      <= 1'b0;
                        r_init_over <= 1'b0;
                        r_cfg_err   <= 1'b0;
                        r_err_idx   <= '0;
                        r_idx       <= '0;
                        r_tries     <= '0;
                        r_state     <= S_FETCH;
                    end
                end

                // tbl_addr already equals r_idx; ROM data lands during DECODE
                S_FETCH: r_state <= S_DECODE;

                S_DECODE: begin
                    case (tbl_data[41:40])
                        c_OP_WRITE, c_OP_POLL: begin
                            r_dev   <= tbl_data[39:32];
                            r_wr    <= (tbl_data[41:40] == c_OP_WRITE);
                            r_addr  <= tbl_data[31:16];
                            r_data  <= tbl_data[15:8];
                            r_mask  <= tbl_data[7:0];
                            r_tries <= '0;
                            r_state <= S_TRIG;
                        end
                        c_OP_DELAY: begin
                            r_units <= tbl_data[31:8];
                            r_pre   <= '0;
                            r_state <= (tbl_data[31:8] == 24'd0) ? S_NEXT : S_DELAY;
                        end
                        default: r_state <= S_DONE;
                    endcase
                end

                S_TRIG: begin
                    if (!busy) begin
                        r_trig  <= 1'b1;
                        r_tmo   <= '0;
                        r_state <= S_WAIT_H;
                    end
                end

                S_WAIT_H: begin
                    if (busy) begin
                        r_tmo   <= '0;
                        r_state <= S_WAIT_L;
                    end else if (r_tmo == c_TMO_W'(BUSY_TO - 1)) begin
                        r_state <= S_ERR;
                    end else begin
                        r_tmo <= r_tmo + c_TMO_W'(1);
                    end
                end

                S_WAIT_L: begin
                    if (!busy) begin
                        r_rdata <= data_out;
                        r_state <= S_CHECK;
                    end else if (r_tmo == c_TMO_W'(BUSY_TO - 1)) begin
                        r_state <= S_ERR;
                    end else begin
                        r_tmo <= r_tmo + c_TMO_W'(1);
                    end
                end

                S_CHECK: begin
                    if (r_wr || ((r_rdata & r_mask) == (r_data & r_mask))) begin
                        r_tries <= '0;
                        r_state <= S_NEXT;
                    end else if (r_tries < 8'(POLL_MAX - 1)) begin
                        r_tries <= r_tries + 8'd1;
                        if (POLL_GAP == 0) begin
                            r_state <= S_TRIG;
                        end else begin
                            r_units <= 24'(POLL_GAP);
                            r_pre   <= '0;
                            r_state <= S_GAP;
                        end
                    end else begin
                        r_state <= S_ERR;
                    end
                end

                // Shared unit timer. DELAY leaves straight for the next FETCH
                // (skipping NEXT) so the total stays at units*DLY_DIV + 1.
                S_DELAY, S_GAP: begin
                    if (r_pre == c_PRE_W'(DLY_DIV - 1)) begin
                        r_pre   <= '0;
                        r_units <= r_units - 24'd1;
                        if (r_units == 24'd1) begin
                            if (r_state == S_GAP) begin
                                r_state <= S_TRIG;
                            end else if (r_idx == c_IDX_MAX) begin
                                r_state <= S_ERR;
                            end else begin
                                r_idx   <= r_idx + TBL_AW'(1);
                                r_state <= S_FETCH;
                            end
                        end
                    end else begin
                        r_pre <= r_pre + c_PRE_W'(1);
                    end
                end

                // Running off the end of the table is an error, never a wrap.
                S_NEXT: begin
                    if (r_idx == c_IDX_MAX) begin
                        r_state <= S_ERR;
                    end else begin
                        r_idx   <= r_idx + TBL_AW'(1);
                        r_state <= S_FETCH;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign tbl_addr  = r_idx;
    assign device_id = r_dev;
    assign iic_trig  = r_trig;
    assign w_r       = r_wr;
    assign addr      = r_addr;
    assign data_in   = r_data;
    assign init_over = r_init_over;
    assign cfg_err   = r_cfg_err;
    assign err_idx   = r_err_idx;

endmodule
`default_nettype wire

// File: tb/tb_iic_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_iic_cfg_seq
// Purpose  : Self-checking bench for iic_cfg_seq. A table ROM and an iic_dri
//            responder model drive the DUT; expected transfers and outcomes
//            are derived by walking the table with the entry rules and kept
//            in a queue that a monitor checks against every iic_trig.
// Revision : 1.0 - initial release
// ============================================================================
module tb_iic_cfg_seq;

    localparam int TBL_AW   = 4;
    localparam int DLY_DIV  = 10;
    localparam int POLL_MAX = 4;
    localparam int POLL_GAP = 1;
    localparam int BUSY_TO  = 200;
    localparam int N_ENT    = 1 << TBL_AW;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              cfg_start = 1'b0;
    logic [TBL_AW-1:0] tbl_addr;
    logic [41:0]       tbl_data;
    logic [7:0]        device_id;
    logic              iic_trig;
    logic              w_r;
    logic [15:0]       addr;
    logic [7:0]        data_in;
    logic              busy = 1'b0;
    logic [7:0]        data_out = 8'd0;
    logic              byte_over = 1'b0;
    logic              init_over;
    logic              cfg_err;
    logic [TBL_AW-1:0] err_idx;

    iic_cfg_seq #(
        .TBL_AW  (TBL_AW),
        .DLY_DIV (DLY_DIV),
        .POLL_MAX(POLL_MAX),
        .POLL_GAP(POLL_GAP),
        .BUSY_TO (BUSY_TO)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .cfg_start(cfg_start),
        .tbl_addr (tbl_addr),
        .tbl_data (tbl_data),
        .device_id(device_id),
        .iic_trig (iic_trig),
        .w_r      (w_r),
        .addr     (addr),
        .data_in  (data_in),
        .busy     (busy),
        .data_out (data_out),
        .byte_over(byte_over),
        .init_over(init_over),
        .cfg_err  (cfg_err),
        .err_idx  (err_idx)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // table ROM with one clock of read latency
    logic [41:0] rom [N_ENT];
    always @(posedge clk) tbl_data <= rom[tbl_addr];

    typedef struct packed {
        logic [7:0]  dev;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        retry;
    } xact_t;

    xact_t      exp_q[$];
    logic [7:0] resp_q[$];
    logic [7:0] force_q[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    bit         exp_done, exp_err;
    logic [TBL_AW-1:0] exp_eidx;
    bit         dead = 1'b0;
    int         lat_min = 1, lat_max = 4, len_min = 2, len_max = 10;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic check_rng(input string name, input longint act, input longint lo, input longint hi);
        n_tests++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic logic [41:0] ent(input logic [1:0] op, input logic [7:0] dev,
                                        input logic [15:0] a, input logic [7:0] d,
                                        input logic [7:0] m);
        return {op, dev, a, d, m};
    endfunction

    function automatic logic [41:0] rnd_write();
        return ent(2'b00, 8'($urandom), 16'($urandom), 8'($urandom), 8'($urandom));
    endfunction

    task automatic fill_rom_random();
        for (int i = 0; i < N_ENT; i++) rom[i] = rnd_write();
    endtask

    // Reference: walk the table by the entry rules, emitting expected
    // transfers, poll read-back values, and the final outcome.
    task automatic build_expected();
        int idx;
        logic [41:0] e;
        logic [1:0]  op;
        logic [7:0]  r;
        bit          hit;
        idx = 0;
        exp_done = 1'b0; exp_err = 1'b0; exp_eidx = '0;
        forever begin
            e  = rom[idx];
            op = e[41:40];
            if (op == 2'b11) begin
                exp_done = 1'b1;
                break;
            end
            if (dead && (op == 2'b00 || op == 2'b01)) begin
                exp_q.push_back({e[39:32], op == 2'b00, e[31:16], e[15:8], 1'b0});
                exp_err = 1'b1; exp_eidx = TBL_AW'(idx);
                break;
            end
            if (op == 2'b00) begin
                exp_q.push_back({e[39:32], 1'b1, e[31:16], e[15:8], 1'b0});
            end else if (op == 2'b01) begin
                hit = 1'b0;
                for (int a = 0; a < POLL_MAX; a++) begin
                    exp_q.push_back({e[39:32], 1'b0, e[31:16], e[15:8], a > 0});
                    if (force_q.size() > 0)       r = force_q.pop_front();
                    else if ($urandom_range(1, 0) == 1) r = (e[15:8] & e[7:0]) | (8'($urandom) & ~e[7:0]);
                    else                          r = 8'($urandom);
                    resp_q.push_back(r);
                    if ((r & e[7:0]) == (e[15:8] & e[7:0])) begin
                        hit = 1'b1;
                        break;
                    end
                end
                if (!hit) begin
                    exp_err = 1'b1; exp_eidx = TBL_AW'(idx);
                    break;
                end
            end
            if (idx == N_ENT - 1) begin
                exp_err = 1'b1; exp_eidx = TBL_AW'(idx);
                break;
            end
            idx++;
        end
    endtask

    // iic_dri responder: after a trigger, wait a latency, hold busy, then
    // drop busy with read data (next queued poll value for reads).
    initial begin : iic_model
        int   phase;
        int   cnt;
        logic rd;
        phase = 0; cnt = 0; rd = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!rstn) begin
                busy  = 1'b0;
                phase = 0;
            end else begin
                case (phase)
                    0: if (iic_trig && !dead) begin
                        rd    = !w_r;
                        cnt   = $urandom_range(lat_max, lat_min);
                        phase = 1;
                    end
                    1: if (cnt == 0) begin
                        busy  = 1'b1;
                        cnt   = $urandom_range(len_max, len_min);
                        phase = 2;
                    end else cnt--;
                    2: if (cnt == 0) begin
                        busy = 1'b0;
                        if (rd && resp_q.size() > 0) data_out = resp_q.pop_front();
                        else                         data_out = 8'($urandom);
                        phase = 0;
                    end else cnt--;
                    default: phase = 0;
                endcase
            end
        end
    end

    // Scoreboard monitor
    initial begin : monitor
        xact_t       x;
        logic [32:0] cur;
        bit          prev_trig;
        bit          active;
        logic        prev_busy;
        longint      last_t;
        prev_trig = 1'b0; active = 1'b0; prev_busy = 1'b0; last_t = 0; cur = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                active    = 1'b0;
                prev_trig = 1'b0;
                prev_busy = busy;
            end else begin
                if (iic_trig) begin
                    check("trig_single_cycle", prev_trig, 0);
                    check("trig_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        x = exp_q.pop_front();
                        check("trig_fields", {device_id, w_r, addr, data_in},
                              {x.dev, x.wr, x.addr, x.data});
                        if (x.retry) check_rng("poll_gap_clks", cyc - last_t,
                                               DLY_DIV * POLL_GAP, 64'd1000000);
                    end
                    cur    = {device_id, w_r, addr, data_in};
                    active = 1'b1;
                    last_t = cyc;
                end
                if (active && prev_busy && !busy) begin
                    check("fields_held", {device_id, w_r, addr, data_in}, cur);
                    active = 1'b0;
                end
                prev_trig = iic_trig;
                prev_busy = busy;
            end
        end
    end

    task automatic start_seq();
        @(posedge clk); #2 cfg_start = 1'b1;
        @(posedge clk); #2 cfg_start = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int n;
        n = 0;
        while (!(init_over || cfg_err) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_finished"}, n < 20000, 1);
        repeat (20) @(negedge clk);
        check({name, "_init_over"}, init_over, exp_done);
        check({name, "_cfg_err"}, cfg_err, exp_err);
        check({name, "_err_idx"}, err_idx, exp_err ? exp_eidx : '0);
        check({name, "_trigs_left"}, exp_q.size(), 0);
        check({name, "_resps_left"}, resp_q.size(), 0);
        exp_q.delete();
        resp_q.delete();
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int n;
        int d;
        int len;
        int r;

        // T1: single write then END, 50-clock transfers
        fill_rom_random();
        rom[0] = ent(2'b00, 8'hB2, 16'h0003, 8'h5A, 8'h00);
        rom[1] = ent(2'b11, 8'h00, 16'h0000, 8'h00, 8'h00);
        lat_min = 1; lat_max = 4; len_min = 50; len_max = 50;
        build_expected();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {tbl_addr, device_id, iic_trig, w_r, addr, data_in,
                                init_over, cfg_err, err_idx}, 0);
        @(posedge clk); #2 rstn = 1'b1;
        wait_end("t1");

        // T2: poll matches on the third read
        fill_rom_random();
        rom[0] = ent(2'b01, 8'hB2, 16'h0100, 8'h01, 8'h01);
        rom[1] = ent(2'b11, 8'h00, 16'h0000, 8'h00, 8'h00);
        lat_min = 1; lat_max = 1; len_min = 2; len_max = 2;
        force_q = '{8'h00, 8'h00, 8'h03};
        build_expected();
        start_seq();
        wait_end("t2");

        // T3: poll never matches; a mid-run cfg_start must be ignored
        fill_rom_random();
        rom[0] = ent(2'b00, 8'h56, 16'h1234, 8'hA5, 8'h00);
        rom[1] = ent(2'b01, 8'h56, 16'h0200, 8'h01, 8'h01);
        rom[2] = ent(2'b11, 8'h00, 16'h0000, 8'h00, 8'h00);
        force_q = '{8'h00, 8'h00, 8'h00, 8'h00};
        build_expected();
        start_seq();
        repeat (15) @(posedge clk);
        start_seq();
        wait_end("t3");

        // T4: DELAY of 3 units
        fill_rom_random();
        rom[0] = ent(2'b00, 8'h56, 16'h0010, 8'h11, 8'h00);
        rom[1] = ent(2'b10, 8'h00, 16'h0000, 8'h03, 8'h00);
        rom[2] = ent(2'b11, 8'h00, 16'h0000, 8'h00, 8'h00);
        lat_min = 1; lat_max = 3; len_min = 3; len_max = 6;
        build_expected();
        start_seq();
        n = 0;
        while (tbl_addr != 4'd1 && n < 2000) begin @(negedge clk); n++; end
        d = 0;
        while (tbl_addr == 4'd1 && d < 2000) begin @(negedge clk); d++; end
        check_rng("t4_delay_entry_clks", d, 3 * DLY_DIV, 3 * DLY_DIV + 2);
        wait_end("t4");

        // T5: busy never rises -> timeout error, then a clean rerun
        fill_rom_random();
        rom[0] = ent(2'b10, 8'h00, 16'h0000, 8'h00, 8'h00);
        rom[1] = ent(2'b00, 8'hB2, 16'h0040, 8'h77, 8'h00);
        rom[2] = ent(2'b11, 8'h00, 16'h0000, 8'h00, 8'h00);
        dead = 1'b1;
        build_expected();
        start_seq();
        wait_end("t5");
        dead = 1'b0;
        build_expected();
        start_seq();
        check("t5_err_cleared", cfg_err, 0);
        wait_end("t5_rerun");

        // T6: reset while a transfer is in flight
        fill_rom_random();
        for (int i = 0; i < 3; i++) rom[i] = rnd_write();
        rom[3] = ent(2'b11, 8'h00, 16'h0000, 8'h00, 8'h00);
        lat_min = 2; lat_max = 2; len_min = 20; len_max = 20;
        build_expected();
        start_seq();
        n = 0;
        while (!busy && n < 2000) begin @(negedge clk); n++; end
        check("t6_busy_seen", busy, 1);
        repeat (3) @(negedge clk);
        @(posedge clk); #2 rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t6_reset_outputs", {tbl_addr, device_id, iic_trig, w_r, addr, data_in,
                                   init_over, cfg_err, err_idx}, 0);
        exp_q.delete();
        resp_q.delete();
        build_expected();
        @(posedge clk); #2 rstn = 1'b1;
        wait_end("t6");

        // T7: table without END runs off the last entry
        fill_rom_random();
        lat_min = 1; lat_max = 2; len_min = 2; len_max = 4;
        build_expected();
        start_seq();
        wait_end("t7");

        // Random tables
        lat_min = 1; lat_max = 4; len_min = 2; len_max = 10;
        for (int t = 0; t < 20; t++) begin
            fill_rom_random();
            len = $urandom_range(14, 1);
            for (int i = 0; i < len; i++) begin
                r = $urandom_range(9, 0);
                if (r < 5) rom[i] = rnd_write();
                else if (r < 8) rom[i] = ent(2'b01, 8'($urandom), 16'($urandom), 8'($urandom),
                                             ($urandom_range(3, 0) == 0) ? 8'h00 : 8'($urandom));
                else rom[i] = ent(2'b10, 8'($urandom), 16'h0000, 8'($urandom_range(3, 0)), 8'($urandom));
            end
            rom[len] = ent(2'b11, 8'($urandom), 16'($urandom), 8'($urandom), 8'($urandom));
            build_expected();
            start_seq();
            wait_end("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
